// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB-first,
// one bit per clock, and a single-cycle done pulse marks a valid result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, res, res_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, last_bit, s, c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    s         = ra[0] ^ rb[0] ^ carry;
    c         = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    res_shift = res >> 1;
    res_shift[WIDTH-1] = s;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        last_bit = (cnt == LAST);
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load on an accepted start, then one bit per edge; in sub mode rb holds ~b
  // and the carry starts at 1 so the cell computes a + ~b + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      ra    <= a;
      rb    <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= c;
      res   <= res_shift;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        sum      <= res_shift;
        cout     <= c;
        overflow <= carry ^ c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed vectors,
// expected results queued at issue time and checked by a monitor on each done pulse.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t q8[$];
  exp_t q1[$];

  // {a, b, cin, sum, cout, overflow} for the 1-bit cell
  logic [5:0] fa_table [8] = '{6'b000_000, 6'b001_101, 6'b010_100, 6'b011_010,
                               6'b100_100, 6'b101_010, 6'b110_011, 6'b111_110};

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Called just after a falling edge; the following rising edge accepts the start.
  task automatic applyStimulus(input bit wide, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub, input logic [7:0] esum,
                               input logic ecout, input logic eovf);
    exp_t e;
    e.sum  = esum;
    e.cout = ecout;
    e.ovf  = eovf;
    if (wide) begin
      e.cyc = cyc + 1 + 8;
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
      q8.push_back(e);
    end else begin
      e.cyc = cyc + 1 + 1;
      a1 = a[0]; b1 = b[0]; cin1 = cin; sub1 = sub; start1 = 1'b1;
      q1.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q1.size() != 0) begin
      checkOutput({name, "_timeout"}, q8.size() + q1.size(), 0);
      q8.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic waitDone8(input string name);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) checkOutput({name, "_done_timeout"}, 0, 1);
  endtask

  // Monitor: every done pulse pops the oldest expectation and compares result and timing.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        checkOutput("w8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        checkOutput("w8_sum", sum8, e.sum);
        checkOutput("w8_cout", cout8, e.cout);
        checkOutput("w8_ovf", ovf8, e.ovf);
        checkOutput("w8_done_cycle", cyc, e.cyc);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checkOutput("w1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        checkOutput("w1_sum", sum1, e.sum);
        checkOutput("w1_cout", cout1, e.cout);
        checkOutput("w1_ovf", ovf1, e.ovf);
        checkOutput("w1_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1;
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_sum", sum8, 0);
    checkOutput("rst_cout", cout8, 0);
    checkOutput("rst_ovf", ovf8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1, 8'h3C, 8'h5A, 0, 0, 8'h96, 0, 1);
    @(negedge clk);
    checkOutput("busy_in_run", busy8, 1);
    waitDrain("add1");
    checkOutput("sum_held_idle", sum8, 8'h96);
    applyStimulus(1, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    waitDrain("add2");
    applyStimulus(1, 8'h7F, 8'h00, 1, 0, 8'h80, 0, 1);
    waitDrain("add3");
    applyStimulus(1, 8'h10, 8'h20, 0, 1, 8'hF0, 0, 0);
    waitDrain("sub1");
    applyStimulus(1, 8'h10, 8'h20, 1, 1, 8'hF0, 0, 0);
    waitDrain("sub_cin_ignored");
    applyStimulus(1, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    waitDrain("sub2");

    // Back-to-back: second start issued while the first result is in DONE.
    applyStimulus(1, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0);
    waitDone8("b2b");
    applyStimulus(1, 8'hA5, 8'h5A, 1, 0, 8'h00, 1, 0);
    waitDrain("b2b");

    // Start pulsed mid-run with different operands must be ignored.
    applyStimulus(1, 8'h0F, 8'hF0, 0, 0, 8'hFF, 0, 0);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDrain("midrun_start");
    repeat (12) @(negedge clk);

    // Reset three cycles into a run aborts it without a clock edge.
    applyStimulus(1, 8'h55, 8'h55, 0, 0, 8'hAA, 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    checkOutput("abort_sum", sum8, 0);
    checkOutput("abort_cout", cout8, 0);
    checkOutput("abort_ovf", ovf8, 0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(1, 8'h01, 8'h01, 0, 0, 8'h02, 0, 0);
    waitDrain("after_reset");

    for (int i = 0; i < 8; i++) begin
      logic [5:0] v;
      v = fa_table[i];
      applyStimulus(0, {7'b0, v[5]}, {7'b0, v[4]}, v[3], 0, {7'b0, v[2]}, v[1], v[0]);
      waitDrain("w1_sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
